fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch / PC sequencing for a five-phase
// (f, r, x, m, w) multicycle core.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   phase[4:0]   one-hot phase {f, r, x, m, w}; all-zero means idle
//   imem_data    instruction word at imem_addr (combinational memory)
//   br_taken     branch decision, sampled in phase x
//   br_target    branch destination, sampled with br_taken
//   restart      single-cycle pulse that leaves HALT
//   imem_addr    instruction address (always equal to pc)
//   pc, ir       program counter, instruction register
//   hlt          halt request to the phase generator (state == HALT)
//   instr_cnt    retired-instruction counter, saturating
//   phase_err    sticky flag: a phase value with two or more bits set was seen
module fetch_ctrl #(
    parameter int              PC_W     = 8,
    parameter int              IR_W     = 16,
    parameter logic [3:0]      HALT_OP  = 4'hF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      phase,
    input  logic [IR_W-1:0] imem_data,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            restart,
    output logic [PC_W-1:0] imem_addr,
    output logic [PC_W-1:0] pc,
    output logic [IR_W-1:0] ir,
    output logic            hlt,
    output logic [15:0]     instr_cnt,
    output logic            phase_err
);

    typedef enum logic {S_RUN, S_HALT} state_t;

    localparam logic [4:0] PH_F = 5'b10000;
    localparam logic [4:0] PH_R = 5'b01000;
    localparam logic [4:0] PH_X = 5'b00100;
    localparam logic [4:0] PH_M = 5'b00010;
    localparam logic [4:0] PH_W = 5'b00001;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            br_pending_q, br_pending_d;
    logic [PC_W-1:0] br_tgt_q, br_tgt_d;
    logic [15:0]     instr_cnt_q, instr_cnt_d;
    logic            phase_err_q, phase_err_d;

    logic            phase_bad;
    logic [PC_W-1:0] pc_inc;
    logic [15:0]     cnt_inc;

    // Two or more bits set: clearing the lowest set bit leaves something.
    assign phase_bad = |(phase & (phase - 5'd1));
    assign pc_inc    = pc_q + PC_W'(1);
    assign cnt_inc   = (instr_cnt_q == 16'hFFFF) ? instr_cnt_q : instr_cnt_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        br_pending_d = br_pending_q;
        br_tgt_d     = br_tgt_q;
        instr_cnt_d  = instr_cnt_q;
        phase_err_d  = phase_err_q;
        case (state_q)
            S_RUN: begin
                // An illegal phase only raises the flag; the cycle is otherwise a no-op.
                if (phase_bad) begin
                    phase_err_d = 1'b1;
                end else begin
                    case (phase)
                        PH_F: ir_d = imem_data;
                        PH_R: if (ir_q[IR_W-1 -: 4] == HALT_OP) state_d = S_HALT;
                        PH_X: begin
                            br_pending_d = br_taken;
                            br_tgt_d     = br_target;
                        end
                        PH_W: begin
                            pc_d         = br_pending_q ? br_tgt_q : pc_inc;
                            br_pending_d = 1'b0;
                            instr_cnt_d  = cnt_inc;
                        end
                        default: ;
                    endcase
                end
            end
            S_HALT: begin
                // Phase is ignored while halted; restart retires the halt instruction.
                if (restart) begin
                    state_d      = S_RUN;
                    pc_d         = pc_inc;
                    instr_cnt_d  = cnt_inc;
                    br_pending_d = 1'b0;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RUN;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            br_pending_q <= 1'b0;
            br_tgt_q     <= '0;
            instr_cnt_q  <= '0;
            phase_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            br_pending_q <= br_pending_d;
            br_tgt_q     <= br_tgt_d;
            instr_cnt_q  <= instr_cnt_d;
            phase_err_q  <= phase_err_d;
        end
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign hlt       = (state_q == S_HALT);
    assign instr_cnt = instr_cnt_q;
    assign phase_err = phase_err_q;

endmodule
